// File: rtl/wb_queue.sv
// wb_queue: in-order write-back buffer in front of the register file write port.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset (rst==0 clears the queue)
//   enqValid/enqReady producer handshake; enqReg/enqData carry the completed result
//   hold              register file cannot accept a write this cycle (blocks drain only)
//   regWrite          write strobe; writeR/writeRData present the head entry (0 when empty)
//   inR1/inR2         read indices; hit1/byp1, hit2/byp2 return the youngest pending value
//   count/empty       occupancy
module wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enqValid,
    input  logic [AW-1:0]            enqReg,
    input  logic [DW-1:0]            enqData,
    output logic                     enqReady,
    input  logic                     hold,
    output logic                     regWrite,
    output logic [AW-1:0]            writeR,
    output logic [DW-1:0]            writeRData,
    input  logic [AW-1:0]            inR1,
    input  logic [AW-1:0]            inR2,
    output logic                     hit1,
    output logic [DW-1:0]            byp1,
    output logic                     hit2,
    output logic [DW-1:0]            byp2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    ereg  [DEPTH];
    logic [DW-1:0]    edata [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             enq_fire;
    logic             deq_fire;
    logic [PW-1:0]    idx1;
    logic [PW-1:0]    idx2;

    // Handshake and drain strobes; register 0 completes the handshake but is never stored.
    assign empty    = (count == '0);
    assign enqReady = (count < FULL_CNT);
    assign regWrite = !empty && !hold;
    assign enq_fire = enqValid && enqReady && (enqReg != '0);
    assign deq_fire = regWrite;

    assign writeR     = empty ? '0 : ereg[head];
    assign writeRData = empty ? '0 : edata[head];

    // Queue state; enqueue and drain never touch the same slot since drain needs count>0
    // and enqueue needs count<DEPTH, so tail==head only occurs when one of them is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ereg[i]  <= '0;
                edata[i] <= '0;
            end
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq_fire) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (enq_fire) begin
                valid[tail] <= 1'b1;
                ereg[tail]  <= enqReg;
                edata[tail] <= enqData;
                tail        <= tail + 1'b1;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bypass: walk oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        hit1 = 1'b0;
        byp1 = '0;
        hit2 = 1'b0;
        byp2 = '0;
        idx1 = '0;
        idx2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx1 = head + PW'(i);
            idx2 = head + PW'(i);
            if (inR1 != '0 && valid[idx1] && ereg[idx1] == inR1) begin
                hit1 = 1'b1;
                byp1 = edata[idx1];
            end
            if (inR2 != '0 && valid[idx2] && ereg[idx2] == inR2) begin
                hit2 = 1'b1;
                byp2 = edata[idx2];
            end
        end
    end

endmodule
